fetch_queue: RTL and testbench

Instruction buffer between the fetch side (program counter and instruction memory) and the decode stage of the 64-bit ARM CPU. It holds up to DEPTH fetched {pc, instruction} pairs, so fetch keeps running while decode is stalled. It also discards everything in flight when a taken branch redirects the PC. Valid/ready handshakes are used on both sides.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/fetch_queue_mem.sv | 32 +++
 rtl/fetch_queue.sv | 91 +++++++++
 tb/tb_fetch_queue.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: the fetch-side record type and fetch-queue defaults.
package cpu_pkg;

  // One fetched instruction together with the address it was fetched from.
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Byte stride between sequential A64 instructions.
  localparam logic [63:0] INSTR_BYTES   = 64'd4;

  // Default number of entries in the fetch queue.
  localparam int          FETCH_Q_DEPTH = 4;

endpackage : cpu_pkg

// File: rtl/fetch_queue_mem.sv
// Storage array for the fetch queue: DEPTH fetch entries, one synchronous
// write port and one combinational read port.
module fetch_queue_mem
  import cpu_pkg::*;
#(
  parameter int DEPTH = FETCH_Q_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  fetch_entry_t  wdata,
  input  logic [AW-1:0] raddr,
  output fetch_entry_t  rdata
);

  fetch_entry_t mem [DEPTH];

  // Capture the written entry on the rising edge.
  // NOTE: the data array carries no reset; occupancy lives in the pointers and
  // count, and stale slots are never observed because the read side is gated
  // by out_valid in the parent.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Head entry is visible without a clock edge.
  assign rdata = mem[raddr];

endmodule : fetch_queue_mem

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode. Holds up to DEPTH {pc, instr}
// pairs with valid/ready handshakes on both sides; flush discards everything.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH   = FETCH_Q_DEPTH,
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_pc,
  input  logic [INSTR_W-1:0]       in_instr,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_W-1:0]        out_pc,
  output logic [INSTR_W-1:0]       out_instr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             push;
  logic             pop;
  fetch_entry_t     wdata;
  fetch_entry_t     rdata;

  // Handshake status depends on occupancy only, never on the other side's
  // request, so a full queue refuses a push even when a pop is in progress.
  assign in_ready  = (count != CNT_FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid  && in_ready;
  assign pop       = out_valid && out_ready;

  assign wdata.pc    = in_pc;
  assign wdata.instr = in_instr;

  fetch_queue_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push && !flush),
    .waddr (wptr),
    .wdata (wdata),
    .raddr (rptr),
    .rdata (rdata)
  );

  // Pointer and occupancy update; flush overrides any push or pop.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + PTR_ONE;
      end
      if (pop) begin
        rptr <= rptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Present the head entry; forced to zero while empty so the uninitialised
  // array never leaks unknown values to decode.
  assign out_pc    = out_valid ? rdata.pc    : '0;
  assign out_instr = out_valid ? rdata.instr : '0;

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_fetch_queue;
  import cpu_pkg::*;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  count;

  int n_checks;
  int n_fails;

  fetch_entry_t model [$];

  fetch_queue #(
    .DEPTH   (DEPTH),
    .ADDR_W  (64),
    .INSTR_W (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every visible output against the reference queue.
  task automatic compare_all(input string tag);
    check({tag, ".count"},     64'(count),     64'(model.size()));
    check({tag, ".out_valid"}, 64'(out_valid), 64'(model.size() != 0));
    check({tag, ".in_ready"},  64'(in_ready),  64'(model.size() != DEPTH));
    if (model.size() != 0) begin
      check({tag, ".out_pc"},    out_pc,           model[0].pc);
      check({tag, ".out_instr"}, 64'(out_instr),   64'(model[0].instr));
    end
  endtask

  // Drive one cycle of stimulus, advance the model by the same rules, check.
  task automatic step(input string tag, input logic v, input logic r, input logic f,
                      input logic [63:0] pc, input logic [31:0] ins);
    bit do_push;
    bit do_pop;
    fetch_entry_t e;
    in_valid  = v;
    out_ready = r;
    flush     = f;
    in_pc     = pc;
    in_instr  = ins;
    do_push   = v && (model.size() < DEPTH);
    do_pop    = r && (model.size() != 0);
    @(posedge clk);
    if (f) begin
      model.delete();
    end else begin
      if (do_pop) void'(model.pop_front());
      if (do_push) begin
        e.pc    = pc;
        e.instr = ins;
        model.push_back(e);
      end
    end
    #1;
    compare_all(tag);
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    in_pc     = '0;
    in_instr  = '0;
  endtask

  initial begin
    logic [63:0] pc;
    idle_inputs();
    n_checks = 0;
    n_fails  = 0;

    // Reset state.
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.count",     64'(count),     64'd0);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.in_ready",  64'(in_ready),  64'd1);
    check("rst.out_pc",    out_pc,         64'd0);
    check("rst.out_instr", 64'(out_instr), 64'd0);
    reset = 1'b1;

    // First push is visible on the next cycle, no bypass.
    step("push1", 1'b1, 1'b0, 1'b0, 64'h0, 32'hF800_0000);
    check("push1.out_pc_abs",    out_pc,         64'h0);
    check("push1.out_instr_abs", 64'(out_instr), 64'hF800_0000);
    check("push1.count_abs",     64'(count),     64'd1);
    step("drain1", 1'b0, 1'b1, 1'b0, 64'h0, 32'h0);

    // Fill to DEPTH, then a fifth push is refused.
    for (int i = 0; i < 4; i++) begin
      pc = INSTR_BYTES * 64'(i);
      step("fill", 1'b1, 1'b0, 1'b0, pc, 32'hA000_0000 | 32'(i));
    end
    check("full.count_abs",    64'(count),    64'd4);
    check("full.in_ready_abs", 64'(in_ready), 64'd0);
    step("push5_refused", 1'b1, 1'b0, 1'b0, 64'h10, 32'hDEAD_BEEF);
    check("push5.count_abs", 64'(count), 64'd4);

    // Pops return the entries in order.
    for (int i = 0; i < 4; i++) begin
      check("pop_order.out_pc", out_pc, INSTR_BYTES * 64'(i));
      step("pop_order", 1'b0, 1'b1, 1'b0, 64'h0, 32'h0);
    end
    check("empty.out_valid_abs", 64'(out_valid), 64'd0);

    // Empty queue ignores out_ready.
    step("empty_pop", 1'b0, 1'b1, 1'b0, 64'h0, 32'h0);

    // Full with simultaneous push and pop: only the pop happens.
    for (int i = 0; i < 4; i++) begin
      pc = INSTR_BYTES * 64'(i);
      step("refill", 1'b1, 1'b0, 1'b0, pc, 32'hB000_0000 | 32'(i));
    end
    step("full_pushpop", 1'b1, 1'b1, 1'b0, 64'h10, 32'hB000_0010);
    check("full_pushpop.count_abs",    64'(count),    64'd3);
    check("full_pushpop.in_ready_abs", 64'(in_ready), 64'd1);
    check("full_pushpop.head_abs",     out_pc,        64'h4);

    // Flush with count=3 wins over push and pop.
    step("flush", 1'b1, 1'b1, 1'b1, 64'h20, 32'h0);
    check("flush.count_abs",     64'(count),     64'd0);
    check("flush.out_valid_abs", 64'(out_valid), 64'd0);
    step("post_flush_push", 1'b1, 1'b0, 1'b0, 64'h100, 32'h1234_5678);
    check("post_flush.head_abs", out_pc, 64'h100);
    step("drain2", 1'b0, 1'b1, 1'b0, 64'h0, 32'h0);

    // Streaming: one push and one pop per cycle, pointers wrap.
    for (int i = 0; i < 10; i++) begin
      pc = INSTR_BYTES * 64'(i);
      step("stream", 1'b1, (i != 0), 1'b0, pc, 32'hC000_0000 | 32'(i));
      check("stream.head_abs",  out_pc,      pc);
      check("stream.count_abs", 64'(count),  64'd1);
    end
    step("drain3", 1'b0, 1'b1, 1'b0, 64'h0, 32'h0);

    // Asynchronous reset between edges with two entries held.
    step("pre_rst_a", 1'b1, 1'b0, 1'b0, 64'h40, 32'h1);
    step("pre_rst_b", 1'b1, 1'b0, 1'b0, 64'h44, 32'h2);
    idle_inputs();
    #2;
    reset = 1'b0;
    #1;
    model.delete();
    check("async_rst.count",     64'(count),     64'd0);
    check("async_rst.out_valid", 64'(out_valid), 64'd0);
    check("async_rst.in_ready",  64'(in_ready),  64'd1);
    check("async_rst.out_pc",    out_pc,         64'd0);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    compare_all("after_rst");

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      step("rand",
           1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 15) == 0),
           {$urandom(), $urandom()},
           $urandom());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_fetch_queue
